bsg_tag_serial_decoder: RTL

//  Receive-side endpoint for the serial bsg_tag stream (tag_en/tag_data) that clock-gen

---
 rtl/bsg_tag_serial_pkg.sv | 31 +++
 rtl/bsg_tag_serial_shifter.sv | 28 ++
 rtl/bsg_tag_serial_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bsg_tag_serial_pkg.sv
// Shared types for the serial bsg_tag decoder: FSM states,
// header struct macro and small width helpers.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

// Field order puts nodeID in the LSBs, so a right-shifting
// LSB-first register fills the struct directly.
`define DECLARE_BSG_TAG_SERIAL_HEADER_S(lg_els, lg_len) \
    typedef struct packed {                            \
        logic [lg_len-1:0] len;                        \
        logic              data_not_reset;             \
        logic [lg_els-1:0] node_id;                    \
    } bsg_tag_serial_header_s

package bsg_tag_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DISCARD,
        DONE
    } bsg_tag_serial_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_tag_serial_shifter.sv
// Enable-gated LSB-first shift register with clear.
// Ports: clk_i, reset_i, clear_i, en_i, data_i -> data_o[width_p].

module bsg_tag_serial_shifter #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic               data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    // New bits enter at the MSB; the first bit ends in bit 0.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= {data_i, data_q[width_p-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_tag_serial_decoder.sv
// Serial bsg_tag receive endpoint: start bit, header, payload.
// Ports: clk_i, reset_i, tag_en_i/tag_data_i in; v_o/yumi_i,
// node_id_o, data_not_reset_o, len_o, payload_o, err_len_o,
// overflow_o out.

module bsg_tag_serial_decoder
    import bsg_tag_serial_pkg::*;
#(
    parameter int els_p               = 16,
    parameter int max_payload_width_p = 16,
    localparam int lg_els_lp = `BSG_SAFE_CLOG2(els_p),
    localparam int lg_len_lp =
        `BSG_SAFE_CLOG2(max_payload_width_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           tag_en_i,
    input  logic                           tag_data_i,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic [lg_els_lp-1:0]           node_id_o,
    output logic                           data_not_reset_o,
    output logic [lg_len_lp-1:0]           len_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           err_len_o,
    output logic                           overflow_o
);

    localparam int hdr_w_lp = lg_els_lp + 1 + lg_len_lp;
    localparam int cnt_w_lp =
        `BSG_SAFE_CLOG2(max2(hdr_w_lp, 1 << lg_len_lp));
    localparam int pw_lp = max_payload_width_p;

    `DECLARE_BSG_TAG_SERIAL_HEADER_S(lg_els_lp, lg_len_lp);

    bsg_tag_serial_state_e    state_q;
    logic [cnt_w_lp-1:0]      cnt_q;
    logic [hdr_w_lp-1:0]      hdr_raw;
    logic [pw_lp-1:0]         pay_raw;
    bsg_tag_serial_header_s   hdr_q;
    bsg_tag_serial_header_s   hdr_d;
    logic                     start;
    logic                     hdr_en;
    logic                     pay_en;
    logic [cnt_w_lp-1:0]      len_m1;
    logic                     hdr_last;
    logic                     too_long;

    logic                     v_q;
    logic [lg_els_lp-1:0]     node_q;
    logic                     dnr_q;
    logic [lg_len_lp-1:0]     len_q;
    logic [pw_lp-1:0]         pay_q;
    logic                     err_q;
    logic                     ovf_q;

    assign start  = (state_q == IDLE) && tag_en_i && tag_data_i;
    assign hdr_en = (state_q == HEADER) && tag_en_i;
    assign pay_en = (state_q == PAYLOAD) && tag_en_i;

    bsg_tag_serial_shifter #(.width_p(hdr_w_lp)) u_hdr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start),
        .en_i    (hdr_en),
        .data_i  (tag_data_i),
        .data_o  (hdr_raw)
    );

    bsg_tag_serial_shifter #(.width_p(pw_lp)) u_pay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start),
        .en_i    (pay_en),
        .data_i  (tag_data_i),
        .data_o  (pay_raw)
    );

    assign hdr_q = hdr_raw;
    // Header as it will look once the current bit is shifted in;
    // needed to route on len while its MSB is still on the wire.
    assign hdr_d = {tag_data_i, hdr_raw[hdr_w_lp-1:1]};

    assign len_m1   = cnt_w_lp'(hdr_q.len) - cnt_w_lp'(1);
    assign hdr_last = (cnt_q == cnt_w_lp'(hdr_w_lp - 1));
    assign too_long = hdr_d.len > lg_len_lp'(pw_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            node_q  <= '0;
            dnr_q   <= 1'b0;
            len_q   <= '0;
            pay_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (yumi_i) begin
                v_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= HEADER;
                    end
                end
                HEADER: if (tag_en_i) begin
                    if (hdr_last) begin
                        cnt_q <= '0;
                        if (hdr_d.len == '0) begin
                            state_q <= DONE;
                        end else if (too_long) begin
                            state_q <= DISCARD;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PAYLOAD: if (tag_en_i) begin
                    if (cnt_q == len_m1) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DISCARD: if (tag_en_i) begin
                    if (cnt_q == len_m1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    if (!v_q || yumi_i) begin
                        v_q    <= 1'b1;
                        node_q <= hdr_q.node_id;
                        dnr_q  <= hdr_q.data_not_reset;
                        len_q  <= hdr_q.len;
                        // Payload sits in the top len bits;
                        // align it down to bit 0.
                        pay_q  <= pay_raw >>
                            (lg_len_lp'(pw_lp) - hdr_q.len);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign v_o              = v_q;
    assign node_id_o        = node_q;
    assign data_not_reset_o = dnr_q;
    assign len_o            = len_q;
    assign payload_o        = pay_q;
    assign err_len_o        = err_q;
    assign overflow_o       = ovf_q;

endmodule
